// File: rtl/tq_quant_4x4.sv
// tq_quant_4x4: forward quantizer for one 4x4 integer-DCT block.
// Captures a whole block, quantizes one row per cycle in a 2-stage pipeline, streams rows out.
//
// state | meaning
// IDLE  | ready to capture a new block
// RUN   | issuing rows 0..3 into stage 1
// DRAIN | waiting for the row-3 output handshake
module tq_quant_4x4 #(
  parameter int COEF_WIDTH  = 15,
  parameter int LEVEL_WIDTH = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [16*COEF_WIDTH-1:0]  coef_i,
  input  logic [5:0]                qp_i,
  input  logic                      intra_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [4*LEVEL_WIDTH-1:0]  out_level_o,
  output logic [1:0]                out_row_o,
  output logic                      out_last_o,
  output logic [4:0]                out_nnz_o
);

  localparam int ABS_W  = COEF_WIDTH + 1;
  localparam int MF_W   = 14;
  localparam int PROD_W = ABS_W + MF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int F_W    = 22;
  localparam logic [3:0] COL_ODD = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [15:0][COEF_WIDTH-1:0]  coef_q, coef_d;
  logic [3:0]                   qp_div_q, qp_div_d;
  logic [2:0]                   qp_mod_q, qp_mod_d;
  logic [F_W-1:0]               round_f_q, round_f_d;
  logic [1:0]                   row_cnt_q, row_cnt_d;
  logic                         s1_valid_q, s1_valid_d;
  logic [1:0]                   s1_row_q, s1_row_d;
  logic [3:0]                   s1_sign_q, s1_sign_d;
  logic [3:0][PROD_W-1:0]       s1_prod_q, s1_prod_d;
  logic                         out_valid_q, out_valid_d;
  logic [3:0][LEVEL_WIDTH-1:0]  out_level_q, out_level_d;
  logic [1:0]                   out_row_q, out_row_d;
  logic                         out_last_q, out_last_d;
  logic [4:0]                   out_nnz_q, out_nnz_d;
  logic [4:0]                   nnz_acc_q, nnz_acc_d;

  logic                         stall, accept, issue;
  logic [5:0]                   qp_clamp;
  logic [3:0]                   qp_div_c;
  logic [4:0]                   qbits;
  logic [3:0][COEF_WIDTH-1:0]   coef_raw_c;
  logic [3:0][ABS_W-1:0]        coef_ext_c;
  logic [3:0][ABS_W-1:0]        coef_abs_c;
  logic [3:0][1:0]              cls_c;
  logic [3:0]                   sign_c;
  logic [3:0][PROD_W-1:0]       prod_c;
  logic [3:0][SUM_W-1:0]        sum_c;
  logic [3:0][LEVEL_WIDTH-1:0]  mag_c;
  logic [3:0][LEVEL_WIDTH-1:0]  level_c;
  logic [2:0]                   row_nnz;
  logic [4:0]                   nnz_sum;

  // Class 0 = (even,even), 1 = (odd,odd), 2 = mixed parity.
  function automatic logic [MF_W-1:0] mf_lookup(input logic [2:0] qmod, input logic [1:0] cls);
    logic [MF_W-1:0] mf_a, mf_b, mf_c;
    case (qmod)
      3'd0:    begin mf_a = 14'd13107; mf_b = 14'd5243; mf_c = 14'd8066; end
      3'd1:    begin mf_a = 14'd11916; mf_b = 14'd4660; mf_c = 14'd7490; end
      3'd2:    begin mf_a = 14'd10082; mf_b = 14'd4194; mf_c = 14'd6554; end
      3'd3:    begin mf_a = 14'd9362;  mf_b = 14'd3647; mf_c = 14'd5825; end
      3'd4:    begin mf_a = 14'd8192;  mf_b = 14'd3355; mf_c = 14'd5243; end
      default: begin mf_a = 14'd7282;  mf_b = 14'd2893; mf_c = 14'd4559; end
    endcase
    mf_lookup = (cls == 2'd0) ? mf_a : ((cls == 2'd1) ? mf_b : mf_c);
  endfunction

  // floor(2^(14+idx)/3); intra uses idx = qp_div+1, inter idx = qp_div since 2^q/6 = 2^(q-1)/3.
  function automatic logic [F_W-1:0] round_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    round_lookup = 22'd5461;
      4'd1:    round_lookup = 22'd10922;
      4'd2:    round_lookup = 22'd21845;
      4'd3:    round_lookup = 22'd43690;
      4'd4:    round_lookup = 22'd87381;
      4'd5:    round_lookup = 22'd174762;
      4'd6:    round_lookup = 22'd349525;
      4'd7:    round_lookup = 22'd699050;
      4'd8:    round_lookup = 22'd1398101;
      default: round_lookup = 22'd2796202;
    endcase
  endfunction

  assign stall  = out_valid_q & ~out_ready_i;
  assign accept = (state_q == S_IDLE) & in_valid_i;
  assign issue  = (state_q == S_RUN) & ~stall;
  assign qbits  = 5'd15 + {1'b0, qp_div_q};

  always_comb begin
    qp_clamp = (qp_i > 6'd51) ? 6'd51 : qp_i;
    if      (qp_clamp >= 6'd48) qp_div_c = 4'd8;
    else if (qp_clamp >= 6'd42) qp_div_c = 4'd7;
    else if (qp_clamp >= 6'd36) qp_div_c = 4'd6;
    else if (qp_clamp >= 6'd30) qp_div_c = 4'd5;
    else if (qp_clamp >= 6'd24) qp_div_c = 4'd4;
    else if (qp_clamp >= 6'd18) qp_div_c = 4'd3;
    else if (qp_clamp >= 6'd12) qp_div_c = 4'd2;
    else if (qp_clamp >= 6'd6)  qp_div_c = 4'd1;
    else                        qp_div_c = 4'd0;
  end

  // Stage 1 inputs: row selected by the row counter.
  always_comb begin
    coef_raw_c = '0;
    coef_ext_c = '0;
    coef_abs_c = '0;
    cls_c      = '0;
    sign_c     = '0;
    prod_c     = '0;
    for (int c = 0; c < 4; c++) begin
      coef_raw_c[c] = coef_q[{row_cnt_q, 2'(c)}];
      sign_c[c]     = coef_raw_c[c][COEF_WIDTH-1];
      coef_ext_c[c] = {coef_raw_c[c][COEF_WIDTH-1], coef_raw_c[c]};
      coef_abs_c[c] = sign_c[c] ? -coef_ext_c[c] : coef_ext_c[c];
      cls_c[c]      = (row_cnt_q[0] ^ COL_ODD[c]) ? 2'd2 : {1'b0, row_cnt_q[0]};
      prod_c[c]     = PROD_W'(coef_abs_c[c]) * PROD_W'(mf_lookup(qp_mod_q, cls_c[c]));
    end
  end

  // Stage 2: round, shift, restore sign.
  always_comb begin
    sum_c   = '0;
    mag_c   = '0;
    level_c = '0;
    row_nnz = '0;
    for (int c = 0; c < 4; c++) begin
      sum_c[c]   = SUM_W'(s1_prod_q[c]) + SUM_W'(round_f_q);
      mag_c[c]   = LEVEL_WIDTH'(sum_c[c] >> qbits);
      level_c[c] = s1_sign_q[c] ? -mag_c[c] : mag_c[c];
      row_nnz    = row_nnz + {2'b00, |mag_c[c]};
    end
    nnz_sum = nnz_acc_q + {2'b00, row_nnz};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_RUN;
      S_RUN:   if (issue && (row_cnt_q == 2'd3)) state_d = S_DRAIN;
      S_DRAIN: if (out_valid_q && out_ready_i && out_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    coef_d      = coef_q;
    qp_div_d    = qp_div_q;
    qp_mod_d    = qp_mod_q;
    round_f_d   = round_f_q;
    row_cnt_d   = row_cnt_q;
    nnz_acc_d   = nnz_acc_q;
    s1_valid_d  = s1_valid_q;
    s1_row_d    = s1_row_q;
    s1_sign_d   = s1_sign_q;
    s1_prod_d   = s1_prod_q;
    out_valid_d = out_valid_q;
    out_level_d = out_level_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    out_nnz_d   = out_nnz_q;

    if (issue) row_cnt_d = row_cnt_q + 2'd1;

    if (!stall) begin
      s1_valid_d  = issue;
      s1_row_d    = row_cnt_q;
      s1_sign_d   = sign_c;
      s1_prod_d   = prod_c;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_level_d = level_c;
        out_row_d   = s1_row_q;
        out_last_d  = (s1_row_q == 2'd3);
        out_nnz_d   = (s1_row_q == 2'd3) ? nnz_sum : 5'd0;
        nnz_acc_d   = nnz_sum;
      end else begin
        out_level_d = '0;
        out_row_d   = '0;
        out_last_d  = 1'b0;
        out_nnz_d   = '0;
      end
    end

    if (accept) begin
      coef_d    = coef_i;
      qp_div_d  = qp_div_c;
      qp_mod_d  = 3'(qp_clamp - ({2'b00, qp_div_c} * 6'd6));
      round_f_d = round_lookup(intra_i ? (qp_div_c + 4'd1) : qp_div_c);
      row_cnt_d = '0;
      nnz_acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      coef_q      <= '0;
      qp_div_q    <= '0;
      qp_mod_q    <= '0;
      round_f_q   <= '0;
      row_cnt_q   <= '0;
      nnz_acc_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_row_q    <= '0;
      s1_sign_q   <= '0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_level_q <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      out_nnz_q   <= '0;
    end else begin
      state_q     <= state_d;
      coef_q      <= coef_d;
      qp_div_q    <= qp_div_d;
      qp_mod_q    <= qp_mod_d;
      round_f_q   <= round_f_d;
      row_cnt_q   <= row_cnt_d;
      nnz_acc_q   <= nnz_acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_row_q    <= s1_row_d;
      s1_sign_q   <= s1_sign_d;
      s1_prod_q   <= s1_prod_d;
      out_valid_q <= out_valid_d;
      out_level_q <= out_level_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      out_nnz_q   <= out_nnz_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_level_o = out_level_q;
  assign out_row_o   = out_row_q;
  assign out_last_o  = out_last_q;
  assign out_nnz_o   = out_nnz_q;

endmodule

// File: tb/tb_tq_quant_4x4.sv
// tb_tq_quant_4x4: scoreboard bench for tq_quant_4x4 with an arithmetic reference model.
module tb_tq_quant_4x4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [239:0] coef_i;
  logic [5:0]   qp_i;
  logic         intra_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [59:0]  out_level_o;
  logic [1:0]   out_row_o;
  logic         out_last_o;
  logic [4:0]   out_nnz_o;

  typedef struct packed {
    logic [59:0] lvl;
    logic [1:0]  row;
    logic        last;
    logic [4:0]  nnz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  bit   mon_en = 0;

  int mf_tab [6][3] = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
                        '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};

  tq_quant_4x4 dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .coef_i      (coef_i),
    .qp_i        (qp_i),
    .intra_i     (intra_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_level_o (out_level_o),
    .out_row_o   (out_row_o),
    .out_last_o  (out_last_o),
    .out_nnz_o   (out_nnz_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [14:0] model_level(input int coef, input int qp, input bit intra,
                                              input int r, input int c);
    int q, qbits, cls;
    longint f, mag, lv, a;
    q     = (qp > 51) ? 51 : qp;
    qbits = 15 + q / 6;
    f     = (longint'(1) << qbits) / (intra ? 3 : 6);
    if ((r % 2 == 0) && (c % 2 == 0))      cls = 0;
    else if ((r % 2 == 1) && (c % 2 == 1)) cls = 1;
    else                                   cls = 2;
    a   = (coef < 0) ? -longint'(coef) : longint'(coef);
    mag = (a * mf_tab[q % 6][cls] + f) >> qbits;
    lv  = (coef < 0) ? -mag : mag;
    return 15'(lv);
  endfunction

  function automatic logic [239:0] put(input logic [239:0] v, input int k, input int val);
    logic [239:0] t;
    t = v;
    t[15*k +: 15] = 15'(val);
    return t;
  endfunction

  function automatic logic [239:0] rand_block();
    logic [239:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: v[15*k +: 15] = 15'd0;
        1: v[15*k +: 15] = 15'(int'($urandom_range(0, 400)) - 200);
        2: v[15*k +: 15] = 15'($urandom);
        default: v[15*k +: 15] = ($urandom_range(0, 1) == 1) ? 15'h4000 : 15'h3fff;
      endcase
    end
    return v;
  endfunction

  task automatic push_levels(input logic [239:0] lv);
    exp_t e;
    int   nnz;
    nnz = 0;
    for (int r = 0; r < 4; r++) begin
      e = '0;
      for (int c = 0; c < 4; c++) begin
        e.lvl[15*c +: 15] = lv[15*(r*4+c) +: 15];
        if (lv[15*(r*4+c) +: 15] != 15'd0) nnz++;
      end
      e.row  = 2'(r);
      e.last = (r == 3);
      e.nnz  = (r == 3) ? 5'(nnz) : 5'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_push(input logic [239:0] cv, input logic [5:0] qp, input logic intra);
    logic [239:0] lv;
    lv = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        lv[15*(r*4+c) +: 15] = model_level(int'($signed(cv[15*(r*4+c) +: 15])), int'(qp),
                                           intra, r, c);
    push_levels(lv);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_block(input logic [239:0] cv, input logic [5:0] qp, input logic intra,
                            input bit use_model);
    int n;
    bit acc;
    if (use_model) model_push(cv, qp, intra);
    coef_i     = cv;
    qp_i       = qp;
    intra_i    = intra;
    in_valid_i = 1'b1;
    acc = 0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: block not accepted after %0d cycles, required accept", n);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d rows still expected, required 0", exp_q.size());
    end
  endtask

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      case (ready_mode)
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        2:       out_ready_i = 1'b0;
        default: out_ready_i = 1'b1;
      endcase
    end
  end

  initial begin
    bit   exp_ready;
    bit   prev_stall;
    logic [69:0] snap;
    exp_t e;
    exp_ready  = 1;
    prev_stall = 0;
    snap       = '0;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        checks++;
        if (in_ready_o !== exp_ready) begin
          errors++;
          $display("FAIL in_ready: got %0b required %0b at %0t", in_ready_o, exp_ready, $time);
        end
        if (prev_stall) begin
          checks++;
          if ({out_valid_o, out_level_o, out_row_o, out_last_o, out_nnz_o, 1'b0} !== snap) begin
            errors++;
            $display("FAIL stall_hold: outputs %h changed during stall, required %h",
                     {out_valid_o, out_level_o, out_row_o, out_last_o, out_nnz_o, 1'b0}, snap);
          end
        end
        if (out_valid_o && out_ready_i && !rst_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL row_extra: got row %0d lvl=%h, required no row", out_row_o, out_level_o);
          end else begin
            e = exp_q.pop_front();
            if ({out_level_o, out_row_o, out_last_o, out_nnz_o} !== e) begin
              errors++;
              $display("FAIL row_out: got lvl=%h row=%0d last=%0b nnz=%0d, required lvl=%h row=%0d last=%0b nnz=%0d",
                       out_level_o, out_row_o, out_last_o, out_nnz_o, e.lvl, e.row, e.last, e.nnz);
            end
          end
        end
        if (rst_i) begin
          exp_ready  = 1;
          prev_stall = 0;
        end else begin
          if (exp_ready && in_valid_i) exp_ready = 0;
          if (out_valid_o && out_ready_i && out_last_o) exp_ready = 1;
          prev_stall = out_valid_o && !out_ready_i;
          snap = {out_valid_o, out_level_o, out_row_o, out_last_o, out_nnz_o, 1'b0};
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [239:0] cv, ev;
    bit found;
    int n;

    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    coef_i     = '0;
    qp_i       = '0;
    intra_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    checks++;
    if ({in_ready_o, out_valid_o, out_level_o, out_row_o, out_last_o, out_nnz_o} !== {1'b1, 1'b0, 60'd0, 2'd0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b valid=%0b lvl=%h row=%0d last=%0b nnz=%0d, required ready=1 rest 0",
               in_ready_o, out_valid_o, out_level_o, out_row_o, out_last_o, out_nnz_o);
    end
    mon_en = 1;

    // Two opposite-sign DC/AC coefficients, plus first-row latency.
    cv = put(put('0, 0, 100), 2, -100);
    ev = put(put('0, 0, 40), 2, -40);
    push_levels(ev);
    send_block(cv, 6'd0, 1'b1, 0);
    @(posedge clk_i);
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: out_valid=%0b one cycle after accept, required 0", out_valid_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_row_o !== 2'd0) begin
      errors++;
      $display("FAIL latency_n2: out_valid=%0b row=%0d two cycles after accept, required 1/0",
               out_valid_o, out_row_o);
    end
    wait_drain();

    // Rounding offset, intra vs inter.
    push_levels(put('0, 0, 1));
    send_block(put('0, 0, 2), 6'd0, 1'b1, 0);
    push_levels('0);
    send_block(put('0, 0, 2), 6'd0, 1'b0, 0);
    // Class b at QP 28.
    push_levels(put('0, 5, 6));
    send_block(put('0, 5, 1000), 6'd28, 1'b1, 0);
    push_levels(put('0, 5, -6));
    send_block(put('0, 5, -1000), 6'd28, 1'b0, 0);
    // QP clamp and extreme magnitudes.
    push_levels(put('0, 0, 18));
    send_block(put('0, 0, 16383), 6'd60, 1'b1, 0);
    push_levels(put('0, 0, -6553));
    send_block(put('0, 0, -16384), 6'd0, 1'b1, 0);
    wait_drain();

    // Backpressure on row 1 while the next block is already waiting with in_valid high.
    send_block(rand_block(), 6'($urandom_range(0, 51)), 1'($urandom_range(0, 1)), 1);
    fork
      send_block(rand_block(), 6'($urandom_range(0, 51)), 1'($urandom_range(0, 1)), 1);
      begin
        found = 0;
        n = 0;
        while (!found && n < 50) begin
          @(posedge clk_i);
          #1;
          found = out_valid_o && (out_row_o == 2'd1);
          n++;
        end
        checks++;
        if (!found) begin
          errors++;
          $display("FAIL bp_row1: row 1 not seen within %0d cycles, required it", n);
        end
        ready_mode = 2;
        repeat (3) @(posedge clk_i);
        #1;
        ready_mode = 0;
      end
    join
    wait_drain();

    // Reset while row 2 is pending.
    send_block(rand_block(), 6'($urandom_range(0, 51)), 1'b1, 1);
    found = 0;
    n = 0;
    while (!found && n < 50) begin
      @(posedge clk_i);
      #1;
      found = out_valid_o && (out_row_o == 2'd2);
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_row2: row 2 not seen within %0d cycles, required it", n);
    end
    ready_mode = 2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_flush: out_valid=%0b in_ready=%0b after reset, required 0/1",
               out_valid_o, in_ready_o);
    end
    exp_q.delete();
    ready_mode = 0;
    push_levels(put('0, 10, 200));
    send_block(put('0, 10, 500), 6'd0, 1'b1, 0);
    wait_drain();

    // Randomized blocks with random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 40; i++)
      send_block(rand_block(), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1);
    wait_drain();
    ready_mode = 0;
    repeat (4) @(posedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
